// File: rtl/wb_mem_store_sequencer_pkg.sv
// Shared constants and encodings for the writeback memory-store sequencer.
package wb_pkg;

  localparam int unsigned NSLOT = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_e;

  typedef enum logic {
    WBS_IDLE = 1'b0,
    WBS_BUSY = 1'b1
  } wbs_state_e;

endpackage

// File: rtl/wb_mem_store_sequencer_if.sv
// Writeback-slot request bundle plus WBAQ enqueue port of the store sequencer.
interface wb_mem_store_sequencer_if #(
  parameter int unsigned NSLOT = wb_pkg::NSLOT,
  parameter int unsigned DW    = wb_pkg::DW,
  parameter int unsigned AW    = wb_pkg::AW
);

  logic                  valid_in;
  logic [NSLOT-1:0]      mem_req;
  logic [NSLOT*DW-1:0]   slot_data;
  logic [NSLOT*AW-1:0]   slot_addr;
  logic [1:0]            size_in;
  logic                  stall;
  logic                  done;
  logic                  wbaq_full;
  logic                  mem_ld;
  logic [DW-1:0]         mem_data;
  logic [AW-1:0]         mem_addr;
  logic [1:0]            memsize;

  modport master (
    output valid_in, mem_req, slot_data, slot_addr, size_in, wbaq_full,
    input  stall, done, mem_ld, mem_data, mem_addr, memsize
  );

  modport slave (
    input  valid_in, mem_req, slot_data, slot_addr, size_in, wbaq_full,
    output stall, done, mem_ld, mem_data, mem_addr, memsize
  );

endinterface

// File: rtl/wb_mem_store_sequencer_pe4.sv
// 4-bit lowest-set-bit priority encoder with an exactly-one-bit-set flag.
module pe4_lowest (
  input  logic [3:0] vec,
  output logic [3:0] onehot,
  output logic       single
);

  always_comb begin
    onehot = vec & (~vec + 4'd1);
    single = (vec != 4'd0) && ((vec & (vec - 4'd1)) == 4'd0);
  end

endmodule

// File: rtl/wb_mem_store_sequencer.sv
// Serializes up to NSLOT memory results of one writeback instruction into the
// WBAQ, one store per cycle, stalling writeback until all are enqueued.
module wb_mem_store_sequencer import wb_pkg::*; #(
  parameter int unsigned NSLOT = wb_pkg::NSLOT,
  parameter int unsigned DW    = wb_pkg::DW,
  parameter int unsigned AW    = wb_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_mem_store_sequencer_if.slave  bus,
  output logic [15:0]              stall_cnt
);

  wbs_state_e       state;
  logic [NSLOT-1:0] pend;
  logic [NSLOT-1:0] sel;
  logic [DW-1:0]    dreg [NSLOT];
  logic [AW-1:0]    areg [NSLOT];
  logic [1:0]       sreg;

  logic             last;
  logic             busy;
  logic             issue;
  logic             capture;
  logic [DW-1:0]    md;
  logic [AW-1:0]    ma;

  pe4_lowest u_sel (
    .vec    (pend),
    .onehot (sel),
    .single (last)
  );

  // Store outputs come only from registers and wbaq_full; stall is the one
  // output with a combinational path from the upstream request.
  always_comb begin
    busy    = (state == WBS_BUSY);
    issue   = busy & ~bus.wbaq_full;
    capture = rst & ~busy & bus.valid_in & (|bus.mem_req);
    md      = '0;
    ma      = '0;
    if (issue) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        if (sel[i]) begin
          md = md | dreg[i];
          ma = ma | areg[i];
        end
      end
    end
    bus.mem_ld   = issue;
    bus.mem_data = md;
    bus.mem_addr = ma;
    bus.memsize  = issue ? sreg : 2'b00;
    bus.done     = issue & last;
    bus.stall    = capture | (busy & ~(issue & last));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WBS_IDLE;
      pend      <= '0;
      sreg      <= '0;
      stall_cnt <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        dreg[i] <= '0;
        areg[i] <= '0;
      end
    end else begin
      if (bus.stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      case (state)
        WBS_IDLE: begin
          if (capture) begin
            pend  <= bus.mem_req;
            sreg  <= bus.size_in;
            state <= WBS_BUSY;
            for (int unsigned i = 0; i < NSLOT; i++) begin
              dreg[i] <= bus.slot_data[i*DW +: DW];
              areg[i] <= bus.slot_addr[i*AW +: AW];
            end
          end
        end
        WBS_BUSY: begin
          if (issue) begin
            pend <= pend & ~sel;
            if (last) begin
              state <= WBS_IDLE;
            end
          end
        end
        default: state <= WBS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_store_sequencer.sv
// Scoreboard bench for wb_mem_store_sequencer: expected stores are queued when
// a group is driven and matched against every observed WBAQ enqueue.
module tb_wb_mem_store_sequencer;
  import wb_pkg::*;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  int cyc = 0;
  exp_t sb[$];
  int ld_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wb_mem_store_sequencer_if #(.NSLOT(NSLOT), .DW(DW), .AW(AW)) bus ();

  wb_mem_store_sequencer #(.NSLOT(NSLOT), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1) begin
      tests++;
      if (bus.mem_ld === 1'b1) begin
        ld_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_extra: unexpected store addr=%h data=%h", bus.mem_addr, bus.mem_data);
        end else begin
          e = sb.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_data !== e.data ||
              bus.memsize !== e.size || bus.done !== e.last) begin
            fails++;
            $display("FAIL sb_store: got addr=%h data=%h size=%b done=%b, expected addr=%h data=%h size=%b done=%b",
                     bus.mem_addr, bus.mem_data, bus.memsize, bus.done, e.addr, e.data, e.size, e.last);
          end
        end
      end else if ({bus.mem_data, bus.mem_addr, bus.memsize, bus.done} !== '0) begin
        fails++;
        $display("FAIL idle_outputs: got data=%h addr=%h size=%b done=%b, expected all 0",
                 bus.mem_data, bus.mem_addr, bus.memsize, bus.done);
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NSLOT*DW-1:0] rand_data();
    logic [NSLOT*DW-1:0] v;
    for (int j = 0; j < NSLOT*DW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NSLOT*AW-1:0] rand_addr();
    logic [NSLOT*AW-1:0] v;
    for (int j = 0; j < NSLOT*AW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one group from IDLE and runs it to done; counts only, no checks.
  task automatic drive_group(input logic [NSLOT-1:0] req, input logic [1:0] sz,
                             input logic [NSLOT*DW-1:0] d, input logic [NSLOT*AW-1:0] a,
                             input logic [31:0] full_mask,
                             output int stall_cyc, output int busy_cyc,
                             output int first_ld, output bit timeout);
    int   hi;
    logic dn;
    stall_cyc = 0; busy_cyc = 0; first_ld = -1; timeout = 0; hi = -1;
    for (int i = 0; i < NSLOT; i++) if (req[i]) hi = i;
    for (int i = 0; i < NSLOT; i++)
      if (req[i]) sb.push_back('{a[i*AW +: AW], d[i*DW +: DW], sz, (i == hi)});
    bus.valid_in = 1'b1; bus.mem_req = req; bus.size_in = sz;
    bus.slot_data = d; bus.slot_addr = a; bus.wbaq_full = 1'b0;
    #1;
    if (bus.stall === 1'b1) stall_cyc++;
    tick;
    bus.valid_in = 1'b0;
    bus.mem_req = NSLOT'($urandom);
    bus.size_in = 2'($urandom);
    bus.slot_data = rand_data();
    bus.slot_addr = rand_addr();
    for (int k = 0; ; k++) begin
      if (k >= 32) begin timeout = 1; break; end
      bus.wbaq_full = full_mask[k];
      #1;
      busy_cyc++;
      if (bus.stall === 1'b1) stall_cyc++;
      if (bus.mem_ld === 1'b1 && first_ld < 0) first_ld = k;
      dn = bus.done;
      tick;
      if (dn === 1'b1) break;
    end
    bus.wbaq_full = 1'b0;
    bus.mem_req = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.valid_in = 1'b1; bus.mem_req = '1; bus.size_in = SZ_8B;
    bus.slot_data = rand_data(); bus.slot_addr = rand_addr(); bus.wbaq_full = 1'b0;
    #12;
    tests++;
    if ({bus.mem_ld, bus.stall, bus.done} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: got ld/stall/done=%b, expected 000", {bus.mem_ld, bus.stall, bus.done});
    end
    tests++;
    if ({bus.mem_data, bus.mem_addr, bus.memsize} !== '0) begin
      fails++; $display("FAIL reset_bus: got data=%h addr=%h size=%b, expected 0", bus.mem_data, bus.mem_addr, bus.memsize);
    end
    tests++;
    if (stall_cnt !== 16'h0 || dut.state !== WBS_IDLE) begin
      fails++; $display("FAIL reset_state: got cnt=%h state=%b, expected 0 IDLE", stall_cnt, dut.state);
    end
    bus.valid_in = 1'b0; bus.mem_req = '0;
    tick;
    rst = 1'b1;
    exp_cnt = 0;
    tick;
  endtask

  task automatic test_single;
    logic [NSLOT*DW-1:0] d = rand_data();
    logic [NSLOT*AW-1:0] a = rand_addr();
    int s, b, f; bit to;
    d[1*DW +: DW] = 64'hAB; a[1*AW +: AW] = 32'h1000;
    drive_group(4'b0010, SZ_8B, d, a, 32'h0, s, b, f, to);
    exp_cnt += 1;
    tests++;
    if (to || s != 1 || b != 1 || f != 0) begin
      fails++; $display("FAIL single: got stall=%0d busy=%0d first_ld=%0d to=%0d, expected 1 1 0 0", s, b, f, to);
    end
    tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL single_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_no_req;
    bus.valid_in = 1'b1; bus.mem_req = '0;
    #1;
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++; $display("FAIL no_req_stall: got %b expected 0", bus.stall);
    end
    tick;
    bus.valid_in = 1'b0;
    tests++;
    if (dut.state !== WBS_IDLE || stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL no_req_state: got state=%b cnt=%0d, expected IDLE %0d", dut.state, stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_sparse;
    logic [NSLOT*DW-1:0] d = rand_data();
    logic [NSLOT*AW-1:0] a = rand_addr();
    int s, b, f; bit to;
    a[1*AW +: AW] = 32'h40; a[3*AW +: AW] = 32'h80;
    drive_group(4'b1010, SZ_4B, d, a, 32'h0, s, b, f, to);
    exp_cnt += 2;
    tests++;
    if (to || s != 2 || b != 2 || f != 0) begin
      fails++; $display("FAIL sparse: got stall=%0d busy=%0d first_ld=%0d to=%0d, expected 2 2 0 0", s, b, f, to);
    end
    tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL sparse_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure;
    int s, b, f; bit to;
    drive_group(4'b1111, SZ_2B, rand_data(), rand_addr(), 32'b0110, s, b, f, to);
    exp_cnt += 6;
    tests++;
    if (to || s != 6 || b != 6 || f != 0) begin
      fails++; $display("FAIL backpressure: got stall=%0d busy=%0d first_ld=%0d to=%0d, expected 6 6 0 0", s, b, f, to);
    end
    tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL backpressure_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [NSLOT*DW-1:0] d = rand_data();
    logic [NSLOT*AW-1:0] a = rand_addr();
    int s, b, f; bit to;
    for (int i = 0; i < 3; i++) sb.push_back('{a[i*AW +: AW], d[i*DW +: DW], SZ_4B, (i == 2)});
    bus.valid_in = 1'b1; bus.mem_req = 4'b0111; bus.size_in = SZ_4B;
    bus.slot_data = d; bus.slot_addr = a; bus.wbaq_full = 1'b0;
    tick;
    bus.valid_in = 1'b0; bus.mem_req = '0;
    tick;
    rst = 1'b0;
    #1;
    tests++;
    if (sb.size() != 2) begin
      fails++; $display("FAIL reset_mid_issued: got %0d stores left expected 2", sb.size());
    end
    sb.delete();
    tests++;
    if ({bus.mem_ld, bus.stall, bus.done, bus.mem_data, bus.mem_addr, bus.memsize} !== '0 ||
        stall_cnt !== 16'h0 || dut.state !== WBS_IDLE) begin
      fails++; $display("FAIL reset_mid_outputs: got ld=%b stall=%b done=%b cnt=%h state=%b, expected all 0 IDLE",
                        bus.mem_ld, bus.stall, bus.done, stall_cnt, dut.state);
    end
    tick; tick;
    rst = 1'b1;
    exp_cnt = 0;
    tick;
    drive_group(4'b0001, SZ_1B, rand_data(), rand_addr(), 32'h0, s, b, f, to);
    exp_cnt += 1;
    tests++;
    if (to || s != 1 || b != 1 || stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL reset_mid_next: got stall=%0d busy=%0d cnt=%0d to=%0d, expected 1 1 %0d 0", s, b, stall_cnt, to, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int s0, b0, f0, s1, b1, f1; bit t0, t1;
    ld_cyc.delete();
    drive_group(4'b0001, SZ_8B, rand_data(), rand_addr(), 32'h0, s0, b0, f0, t0);
    drive_group(4'b0100, SZ_2B, rand_data(), rand_addr(), 32'h0, s1, b1, f1, t1);
    exp_cnt += 2;
    tests++;
    if (t0 || t1 || s1 != 1 || b1 != 1) begin
      fails++; $display("FAIL b2b_second: got stall=%0d busy=%0d to=%0d/%0d, expected 1 1 0/0", s1, b1, t0, t1);
    end
    tests++;
    if (ld_cyc.size() != 2) begin
      fails++; $display("FAIL b2b_count: got %0d loads expected 2", ld_cyc.size());
    end else if (ld_cyc[1] - ld_cyc[0] != 2) begin
      fails++; $display("FAIL b2b_gap: got %0d cycles expected 2", ld_cyc[1] - ld_cyc[0]);
    end
    tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL b2b_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  // Drives the counter to 16'hFFFE by holding the WBAQ full, then 5 more cycles.
  task automatic test_saturation;
    logic [NSLOT*DW-1:0] d = rand_data();
    logic [NSLOT*AW-1:0] a = rand_addr();
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    sb.push_back('{a[AW-1:0], d[DW-1:0], SZ_8B, 1'b1});
    bus.valid_in = 1'b1; bus.mem_req = 4'b0001; bus.size_in = SZ_8B;
    bus.slot_data = d; bus.slot_addr = a; bus.wbaq_full = 1'b0;
    tick;
    bus.valid_in = 1'b0; bus.mem_req = '0; bus.wbaq_full = 1'b1;
    repeat (65533) tick;
    tests++;
    if (stall_cnt !== 16'hFFFE) begin
      fails++; $display("FAIL sat_pre: got %h expected fffe", stall_cnt);
    end
    repeat (5) tick;
    tests++;
    if (stall_cnt !== 16'hFFFF || bus.stall !== 1'b1 || bus.mem_ld !== 1'b0) begin
      fails++; $display("FAIL sat_hold: got cnt=%h stall=%b ld=%b, expected ffff 1 0", stall_cnt, bus.stall, bus.mem_ld);
    end
    bus.wbaq_full = 1'b0;
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL sat_done: got done=%b stall=%b, expected 1 0", bus.done, bus.stall);
    end
    tick;
    tests++;
    if (stall_cnt !== 16'hFFFF || dut.state !== WBS_IDLE) begin
      fails++; $display("FAIL sat_end: got cnt=%h state=%b, expected ffff IDLE", stall_cnt, dut.state);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_no_req;
    test_sparse;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_saturation;
    tick;
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_mem_store_sequencer.md
# wb_mem_store_sequencer

Serializes the up-to-four memory results of one writeback-stage instruction into the write-back address queue (WBAQ), one store per cycle. It sits between the writeback stage's memory-result slots and the WBAQ enqueue port. It holds the writeback stage with `stall` until every requested store has been accepted, so multi-destination memory instructions never drop or merge writes.

## Interface
Parameters:
- `NSLOT`, 4: number of result slots.
- `DW`, 64: data width per slot.
- `AW`, 32: address width per slot.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  writeback instruction valid this cycle.
- `mem_req`  in  NSLOT  per-slot store request; slot i is `isMem & wb` for slot i.
- `slot_data`  in  NSLOT*DW  slot i data at bits [i*DW +: DW].
- `slot_addr`  in  NSLOT*AW  slot i address at bits [i*AW +: AW].
- `size_in`  in  2  store size: 00=1B, 01=2B, 10=4B, 11=8B.
- `wbaq_full`  in  1  WBAQ cannot accept this cycle.
- `mem_ld`  out  1  enqueue strobe to the WBAQ.
- `mem_data`  out  DW  store data.
- `mem_addr`  out  AW  store address.
- `memsize`  out  2  store size.
- `stall`  out  1  hold the writeback stage.
- `done`  out  1  one-cycle pulse when the final store of a group is enqueued.
- `stall_cnt`  out  16  saturating count of cycles with `stall` high.

## Operation
- State is 1 bit: IDLE or BUSY. The datapath registers are:
  - `pend[NSLOT]`
  - `dreg[NSLOT]`
  - `areg[NSLOT]`
  - `sreg`

**IDLE**
- If `valid_in & |mem_req`:
  - latch `pend<=mem_req`, all slot data and addresses, and `sreg<=size_in`;
  - go to BUSY;
  - assert `stall` combinationally this cycle.
- Otherwise stay in IDLE with `stall=0`.
- `valid_in` with `mem_req==0` takes no action.

**BUSY**
- `sel` is the lowest-index set bit of `pend`.
- `mem_ld = ~wbaq_full`. When `mem_ld` is high:
  - `mem_data=dreg[sel]`, `mem_addr=areg[sel]`, `memsize=sreg`;
  - clear `pend[sel]` at the edge.
- When `mem_ld` is low, `mem_data`, `mem_addr` and `memsize` are driven to 0.
- If `mem_ld` fires and `pend` has exactly one bit set:
  - assert `done`;
  - deassert `stall` this cycle;
  - go to IDLE.
- Otherwise keep `stall=1`.
- `valid_in`, `mem_req`, `slot_*` and `size_in` are ignored while BUSY. Upstream holds them stable because `stall` is high.

**stall_cnt**
- Increments on every edge where `stall=1`.
- Saturates at 16'hFFFF.

## Timing
- Reset, asynchronous on `rst=0`:
  - state=IDLE;
  - `pend`, `dreg`, `areg`, `sreg` = 0;
  - `stall_cnt`=0.
- All outputs are 0 during reset.
- `mem_ld`, `mem_data`, `mem_addr`, `memsize` and `done` depend only on registers and `wbaq_full`. There is no combinational path from `slot_*` to them.
- `stall` in IDLE is combinational from `valid_in` and `mem_req`.
- Latency: N requested slots with the WBAQ never full takes 1 capture cycle plus N BUSY cycles. Total `stall` high = N cycles, because `stall` drops in the last issue cycle.
- `wbaq_full` high in BUSY: no issue and no `pend` change; `stall` stays 1. Back-to-back full cycles extend the group indefinitely.
- The ordering slot0→slot3 is fixed regardless of the `mem_req` pattern. Gaps in `mem_req` are skipped with no bubble.
- Reset asserted mid-group: pending stores are discarded and the block returns to IDLE immediately.
- In the cycle BUSY→IDLE, a new `valid_in` is not captured. Upstream advances on that edge and presents the next instruction in the following cycle.

## Structure
- Shared package `wb_pkg`:
  - `NSLOT`, `DW`, `AW`;
  - size encodings `SZ_1B`…`SZ_8B`;
  - state encoding `WBS_IDLE=1'b0`, `WBS_BUSY=1'b1`.
- Sub-module `pe4_lowest`:
  - input 4-bit vector;
  - outputs one-hot lowest set bit and `single` (exactly one bit set);
  - used for `sel`, `done` and the last-issue decision.
- Slot muxes use the one-hot `sel`.

## Test plan
- Single store: `mem_req=0010`, `slot_addr[1]=32'h1000`, `slot_data[1]=64'hAB`, `wbaq_full=0`.
  - One BUSY cycle with `mem_ld=1`, `mem_addr=32'h1000`, `mem_data=64'hAB`, `done=1`.
  - `stall` high for exactly 1 cycle.
- Sparse group: `mem_req=1010`, addresses 0x40 (slot 1) and 0x80 (slot 3).
  - Enqueues 0x40 then 0x80 on consecutive cycles.
  - `done` only on the second; `stall` high for 2 cycles.
- Backpressure: `mem_req=1111` with `wbaq_full` high for BUSY cycles 2–3.
  - Stores appear in order 0,1,2,3 over 6 BUSY cycles.
  - No duplicate or lost enqueue; `stall_cnt` increases by 6.
- Reset mid-group: `mem_req=0111`, pull `rst` low after the first enqueue.
  - All outputs are 0 and state is IDLE.
  - The next `mem_req=0001` after release issues only slot 0.
- Back-to-back instructions: `mem_req=0001` followed immediately by `mem_req=0100`.
  - The second is captured one cycle after `done`.
  - The two `mem_ld` pulses are separated by exactly one capture cycle.
- Saturation: force `stall_cnt` to 16'hFFFE, then hold `wbaq_full=1` for 5 BUSY cycles → `stall_cnt` reads 16'hFFFF.
